multdiv: RTL and testbench

Iterative signed 32-bit multiply/divide unit. It sits in the execute stage directly downstream of the instruction decoder's mul/div outputs. The pipeline control turns the decoder's mul/div flags into single-cycle ctrl_MULT/ctrl_DIV start pulses. The pipeline stalls on busy and writes data_result back when data_resultRDY pulses.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/addsub33.sv | 16 +
 rtl/multdiv.sv | 194 +++++++++++++++++++
 tb/tb_multdiv.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
// Holds the control state encoding, the operation select and width defaults.
// Imported by the top and by any block that needs the same enums.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

endpackage

// File: rtl/addsub33.sv
// Purpose: W-bit adder/subtractor (33 bits in the default 32-bit datapath).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module addsub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    // Subtract as a + ~b + 1 so a single carry chain serves add and subtract.
    assign y = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/multdiv.sv
// Purpose: iterative signed multiply (low word + overflow) / divide (quotient + div-by-zero).
// Latency: 32 edges from the start edge to the one-cycle data_resultRDY pulse.
// Backpressure: none; busy flags a running op, and a new start aborts and restarts.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             divz_q, divz_d;
    // opnd: multiplicand for multiply, divisor for divide (magnitudes)
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // hi: product high word / partial remainder
    logic [WIDTH-1:0] hi_q, hi_d;
    // lo: multiplier shifting out + product low bits / dividend shifting out + quotient
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic             start;
    logic             start_mult;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]   step_a, step_b, step_y;
    logic             step_sub;
    logic [WIDTH-1:0] step_hi, step_lo;

    logic [WIDTH:0]   neg_y;
    logic             unused_neg_msb;
    logic [WIDTH-1:0] fin_res;
    logic             fin_exc;
    logic             prod_ge_min, prod_gt_min;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign start_mult = ctrl_MULT;
    assign a_mag      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Operand selection for one iteration: shift-add for multiply, trial subtract for divide.
    always_comb begin
        step_a   = {1'b0, hi_q};
        step_b   = '0;
        step_sub = 1'b0;
        if (op_q == OP_MULT) begin
            step_a   = {1'b0, hi_q};
            step_b   = lo_q[0] ? {1'b0, opnd_q} : '0;
            step_sub = 1'b0;
        end else begin
            step_a   = {hi_q, lo_q[WIDTH-1]};
            step_b   = {1'b0, opnd_q};
            step_sub = 1'b1;
        end
    end

    addsub33 #(.W(WIDTH + 1)) u_step (
        .a   (step_a),
        .b   (step_b),
        .sub (step_sub),
        .y   (step_y)
    );

    // Register update for one iteration; divide restores by keeping the shifted value on borrow.
    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        if (op_q == OP_MULT) begin
            step_hi = step_y[WIDTH:1];
            step_lo = {step_y[0], lo_q[WIDTH-1:1]};
        end else if (!step_y[WIDTH]) begin
            step_hi = step_y[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = step_a[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Two's-complement negate of the final low word (0 - x).
    addsub33 #(.W(WIDTH + 1)) u_neg (
        .a   ('0),
        .b   ({1'b0, step_lo}),
        .sub (1'b1),
        .y   (neg_y)
    );
    assign unused_neg_msb = neg_y[WIDTH];

    // Final sign fix-up and exception; overflow judged on the unsigned product magnitude.
    always_comb begin
        prod_ge_min = (|step_hi) | step_lo[WIDTH-1];
        prod_gt_min = (|step_hi) | (step_lo[WIDTH-1] & (|step_lo[WIDTH-2:0]));
        fin_res     = sign_q ? neg_y[WIDTH-1:0] : step_lo;
        fin_exc     = 1'b0;
        if (op_q == OP_MULT) begin
            // A negative product may reach -2^(WIDTH-1); a positive one must stay below 2^(WIDTH-1).
            fin_exc = sign_q ? prod_gt_min : prod_ge_min;
        end else begin
            fin_exc = divz_q;
            if (divz_q) begin
                fin_res = '0;
            end
        end
    end

    // Control FSM next state and datapath register updates; a start always wins.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        divz_d  = divz_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        exc_d   = exc_q;
        if (start) begin
            state_d = RUN;
            op_d    = start_mult ? OP_MULT : OP_DIV;
            cnt_d   = '0;
            sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            divz_d  = !start_mult && (data_operandB == '0);
            hi_d    = '0;
            opnd_d  = start_mult ? a_mag : b_mag;
            lo_d    = start_mult ? b_mag : a_mag;
        end else begin
            case (state_q)
                RUN: begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        res_d   = fin_res;
                        exc_d   = fin_exc;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            divz_q  <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            divz_q  <= divz_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed corner cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_multdiv;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: {exception, result} from signed 64-bit arithmetic.
    function automatic logic [32:0] model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, lim;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sh0000_0000_7FFF_FFFF;
        if (is_mult) begin
            p = sa * sb;
            r = p[31:0];
            return {(p > lim) || (p < -lim - 1), r};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        p = sa / sb;
        r = p[31:0];
        return {1'b0, r};
    endfunction

    // Present a start at the current negedge, then scramble operands after the start edge.
    task automatic drive_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges after the start edge until RDY; busy must stay high and RDY low before that.
    task automatic wait_rdy(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = (busy === 1'b1) && (data_resultRDY === 1'b0);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clock);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (data_resultRDY === 1'b1) lat = k;
        end
    endtask

    task automatic test_reset();
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", data_result); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset exception: got %b want 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset rdy: got %b want 0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    endtask

    // Directed corners then random operands for one operation type.
    task automatic test_arith(input bit is_mult);
        logic [31:0] a, b;
        logic [32:0] exp;
        int          lat;
        bit          bok;
        string       nm;
        nm = is_mult ? "mult" : "div";
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = 32'($urandom_range(0, 200)) - 32'd100;
            if (i % 3 == 2) begin
                a = 32'($urandom_range(0, 60000)) - 32'd30000;
                b = 32'($urandom_range(0, 60000)) - 32'd30000;
            end
            if (!is_mult && i % 5 == 0) b = 32'h0;
            if (is_mult) begin
                case (i)
                    0: begin a = 32'd7;         b = 32'hFFFF_FFFA; end
                    1: begin a = 32'h0001_0000; b = 32'h0001_0000; end
                    2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    3: begin a = 32'h0;         b = 32'hFFFF_FFFF; end
                    4: begin a = 32'h8000_0000; b = 32'd1;         end
                    5: begin a = 32'h0000_FFFF; b = 32'h0001_0001; end
                    default: ;
                endcase
            end else begin
                case (i)
                    0: begin a = 32'hFFFF_FF9C; b = 32'd7;         end
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: begin a = 32'h0;         b = 32'd123;       end
                    3: begin a = 32'd5;         b = 32'h0;         end
                    4: begin a = 32'd7;         b = 32'hFFFF_FFFE; end
                    5: begin a = 32'hFFFF_FFFF; b = 32'h8000_0000; end
                    default: ;
                endcase
            end
            exp = model(is_mult, a, b);
            drive_start(is_mult, !is_mult, a, b);
            wait_rdy(lat, bok);
            checks++; if (lat != 32) begin errors++; $display("FAIL %s[%0d] latency: got %0d want 32", nm, i, lat); end
            checks++; if (!bok) begin errors++; $display("FAIL %s[%0d] busy/early rdy: busy not held or rdy early", nm, i); end
            checks++; if (data_result !== exp[31:0]) begin errors++; $display("FAIL %s[%0d] result a=%h b=%h: got %h want %h", nm, i, a, b, data_result, exp[31:0]); end
            checks++; if (data_exception !== exp[32]) begin errors++; $display("FAIL %s[%0d] exception a=%h b=%h: got %b want %b", nm, i, a, b, data_exception, exp[32]); end
            @(negedge clock);
            checks++; if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s[%0d] post rdy/busy: got %b/%b want 0/0", nm, i, data_resultRDY, busy); end
            checks++; if (data_result !== exp[31:0]) begin errors++; $display("FAIL %s[%0d] hold: got %h want %h", nm, i, data_result, exp[31:0]); end
        end
    endtask

    // A second start mid-operation aborts the first; both ctrl lines high selects multiply.
    task automatic test_abort();
        int lat;
        bit bok, early;
        logic [31:0] prev;
        prev  = data_result;
        early = 1'b0;
        drive_start(1'b1, 1'b0, 32'd3, 32'd4);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) early = 1'b1;
        end
        drive_start(1'b0, 1'b1, 32'd20, 32'd4);
        checks++; if (data_result !== prev) begin errors++; $display("FAIL abort hold at start: got %h want %h", data_result, prev); end
        wait_rdy(lat, bok);
        checks++; if (early) begin errors++; $display("FAIL abort rdy from aborted mult: got 1 want 0"); end
        checks++; if (lat != 32) begin errors++; $display("FAIL abort latency: got %0d want 32", lat); end
        checks++; if (data_result !== 32'd5 || data_exception !== 1'b0) begin errors++; $display("FAIL abort result: got %h/%b want 00000005/0", data_result, data_exception); end
        @(negedge clock);
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL abort extra rdy: got 1 want 0"); end
        drive_start(1'b1, 1'b1, 32'hFFFF_FFF7, 32'd3);
        wait_rdy(lat, bok);
        checks++; if (lat != 32 || !bok) begin errors++; $display("FAIL both_ctrl latency: got %0d want 32", lat); end
        checks++; if (data_result !== 32'hFFFF_FFE5) begin errors++; $display("FAIL both_ctrl result: got %h want ffffffe5", data_result); end
        @(negedge clock);
    endtask

    // A start in the RDY cycle restarts immediately; outputs hold until the new finalisation.
    task automatic test_back_to_back();
        int lat;
        bit bok;
        logic [31:0] a1, b1, a2, b2;
        logic [32:0] e1, e2;
        a1 = 32'($urandom_range(0, 5000)) - 32'd2500;
        b1 = 32'($urandom_range(0, 5000)) - 32'd2500;
        a2 = $urandom;
        b2 = 32'($urandom_range(1, 1000));
        e1 = model(1'b1, a1, b1);
        e2 = model(1'b0, a2, b2);
        drive_start(1'b1, 1'b0, a1, b1);
        wait_rdy(lat, bok);
        checks++; if (lat != 32 || data_result !== e1[31:0]) begin errors++; $display("FAIL b2b first: lat %0d result %h want 32 %h", lat, data_result, e1[31:0]); end
        drive_start(1'b0, 1'b1, a2, b2);
        checks++; if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b after restart rdy/busy: got %b/%b want 0/1", data_resultRDY, busy); end
        checks++; if (data_result !== e1[31:0]) begin errors++; $display("FAIL b2b hold: got %h want %h", data_result, e1[31:0]); end
        wait_rdy(lat, bok);
        checks++; if (lat != 32 || !bok) begin errors++; $display("FAIL b2b second latency: got %0d want 32", lat); end
        checks++; if (data_result !== e2[31:0] || data_exception !== e2[32]) begin errors++; $display("FAIL b2b second result: got %h/%b want %h/%b", data_result, data_exception, e2[31:0], e2[32]); end
        @(negedge clock);
    endtask

    // Asynchronous reset mid-operation clears outputs at once and suppresses RDY.
    task automatic test_reset_mid();
        int lat, pulses;
        bit bok;
        drive_start(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (15) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid async: got %h/%b/%b/%b want 0/0/0/0", data_result, data_exception, data_resultRDY, busy);
        end
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL reset_mid activity after reset: got %0d want 0", pulses); end
        drive_start(1'b1, 1'b0, 32'd9, 32'd9);
        wait_rdy(lat, bok);
        checks++; if (lat != 32 || data_result !== 32'd81 || data_exception !== 1'b0) begin
            errors++; $display("FAIL reset_mid fresh: lat %0d result %h/%b want 32 00000051/0", lat, data_result, data_exception);
        end
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_arith(1'b1);
        test_arith(1'b0);
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
